// File: rtl/soc_system_pio_multi.sv
// Multi-channel Avalon-MM PIO: N_CH output registers with set/clear/toggle aliases and update
// strobes, plus one synchronised input bank with rising-edge capture and a maskable irq.
module soc_system_pio_multi #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       N_CH      = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int unsigned      CH_W      = $clog2(N_CH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CH_W+1:0]        address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic [N_CH-1:0]        out_strobe,
  input  logic [DATA_W-1:0]      in_port,
  output logic                   irq
);

  localparam logic [CH_W-1:0] InBank  = CH_W'(N_CH);
  localparam logic [1:0]      RegData = 2'd0;
  localparam logic [1:0]      RegSet  = 2'd1;
  localparam logic [1:0]      RegClr  = 2'd2;
  localparam logic [1:0]      RegTgl  = 2'd3;
  localparam logic [1:0]      RegIn   = 2'd0;
  localparam logic [1:0]      RegMask = 2'd1;
  localparam logic [1:0]      RegEdge = 2'd2;

  logic              wr_en;
  logic              in_wr;
  logic [CH_W-1:0]   bank;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] wd;
  logic              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign bank      = address[CH_W+1:2];
  assign reg_sel   = address[1:0];
  assign wd        = writedata[DATA_W-1:0];
  assign in_wr     = wr_en && (bank == InBank);
  // Upper write-data bits are architecturally ignored when DATA_W < 32.
  assign unused_wd = ^writedata;

  // Output channels
  logic [DATA_W-1:0] data_q [N_CH];
  logic [DATA_W-1:0] data_d [N_CH];
  logic [N_CH-1:0]   strobe_q;
  logic [N_CH-1:0]   strobe_d;

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      data_d[c]   = data_q[c];
      strobe_d[c] = 1'b0;
      if (wr_en && (bank == CH_W'(c))) begin
        strobe_d[c] = 1'b1;
        unique case (reg_sel)
          RegData: data_d[c] = wd;
          RegSet:  data_d[c] = data_q[c] | wd;
          RegClr:  data_d[c] = data_q[c] & ~wd;
          RegTgl:  data_d[c] = data_q[c] ^ wd;
          default: data_d[c] = data_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        data_q[c] <= RESET_VAL;
      end
      strobe_q <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        data_q[c] <= data_d[c];
      end
      strobe_q <= strobe_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign out_port[c*DATA_W +: DATA_W] = data_q[c];
  end

  assign out_strobe = strobe_q;

  // Input bank
  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] sync2_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] mask_d;
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] edge_d;
  logic [DATA_W-1:0] edge_clr;

  // New captures are OR-ed in after the W1C so a coincident set wins.
  always_comb begin
    mask_d   = mask_q;
    edge_clr = '0;
    if (in_wr && (reg_sel == RegMask)) begin
      mask_d = wd;
    end
    if (in_wr && (reg_sel == RegEdge)) begin
      edge_clr = wd;
    end
    edge_d = (edge_q & ~edge_clr) | (sync2_q & ~prev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
    end
  end

  assign irq = |(edge_q & mask_q);

  // Read mux: zero wait states, purely combinational from address.
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (bank == InBank) begin
      unique case (reg_sel)
        RegIn:   rd_val = sync2_q;
        RegMask: rd_val = mask_q;
        RegEdge: rd_val = edge_q;
        default: rd_val = '0;
      endcase
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (bank == CH_W'(c)) begin
          rd_val = data_q[c];
        end
      end
    end
    readdata              = '0;
    readdata[DATA_W-1:0] = rd_val;
  end

endmodule

// File: tb/tb_soc_system_pio_multi.sv
// Self-checking bench for soc_system_pio_multi: directed scenarios plus a randomized run
// compared against a behavioural register/delay-line model.
module tb_soc_system_pio_multi;

  localparam int unsigned       DATA_W    = 32;
  localparam int unsigned       N_CH      = 4;
  localparam int unsigned       CH_W      = $clog2(N_CH + 1);
  localparam logic [DATA_W-1:0] RESET_VAL = 32'hC0DE_0005;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [CH_W+1:0]        address;
  logic                   chipselect;
  logic                   write_n;
  logic [31:0]            writedata;
  logic [31:0]            readdata;
  logic [N_CH*DATA_W-1:0] out_port;
  logic [N_CH-1:0]        out_strobe;
  logic [DATA_W-1:0]      in_port;
  logic                   irq;

  int n_checks = 0;
  int n_fail   = 0;

  soc_system_pio_multi #(
    .DATA_W   (DATA_W),
    .N_CH     (N_CH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_strobe(out_strobe),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [CH_W+1:0] adr(input int b, input int r);
    return {CH_W'(b), 2'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int b, input int r, input logic [31:0] d);
    address    = adr(b, r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int b, input int r, output logic [31:0] v);
    address = adr(b, r);
    #1;
    v = readdata;
  endtask

  task automatic do_reset();
    in_port    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp;
    reset_n = 1'b0;
    in_port = '1;
    tick();
    tick();
    tick();
    for (int c = 0; c < N_CH; c++) begin
      n_checks++;
      if (out_port[c*DATA_W +: DATA_W] !== RESET_VAL) begin
        n_fail++;
        $display("FAIL reset_out ch%0d: got %h want %h", c, out_port[c*DATA_W +: DATA_W], RESET_VAL);
      end
    end
    n_checks++;
    if (out_strobe !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe_irq: got %b/%b want 0/0", out_strobe, irq);
    end
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < 4; r++) begin
        rd(b, r, v);
        exp = (b < N_CH) ? 32'(RESET_VAL) : 32'h0;
        n_checks++;
        if (v !== exp) begin
          n_fail++;
          $display("FAIL reset_read b%0d r%0d: got %h want %h", b, r, v, exp);
        end
      end
    end
    // Release with inputs already high: capture lands on the third posedge.
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    rd(N_CH, 0, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL release_in: got %h want ffffffff", v);
    end
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL release_edge_early: got %h want 0", v);
    end
    tick();
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge: got %h irq %b want ffffffff irq 0", v, irq);
    end
    wr(N_CH, 2, 32'hFFFF_FFFF);
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL release_w1c: got %h want 0", v);
    end
    in_port = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_atomic();
    logic [31:0] vals [4];
    logic [31:0] exps [4];
    vals = '{32'h0000_00F0, 32'h0000_000F, 32'h0000_0030, 32'h0000_0101};
    exps = '{32'h0000_00F0, 32'h0000_00FF, 32'h0000_00CF, 32'h0000_01CE};
    for (int r = 0; r < 4; r++) begin
      wr(1, r, vals[r]);
      n_checks++;
      if (readdata !== exps[r] || out_strobe !== 4'b0010) begin
        n_fail++;
        $display("FAIL atomic r%0d: got %h strobe %b want %h strobe 0010",
                 r, readdata, out_strobe, exps[r]);
      end
    end
    wr(1, 1, 32'h0);
    n_checks++;
    if (readdata !== 32'h1CE || out_strobe !== 4'b0010) begin
      n_fail++;
      $display("FAIL set_zero: got %h strobe %b want 000001ce strobe 0010", readdata, out_strobe);
    end
    tick();
    n_checks++;
    if (out_strobe !== 4'b0000) begin
      n_fail++;
      $display("FAIL atomic_strobe_end: got %b want 0000", out_strobe);
    end
    n_checks++;
    if (out_port !== {RESET_VAL, RESET_VAL, 32'h1CE, RESET_VAL}) begin
      n_fail++;
      $display("FAIL atomic_out: got %h want %h", out_port,
               {RESET_VAL, RESET_VAL, 32'h1CE, RESET_VAL});
    end
  endtask

  task automatic test_isolation();
    logic [31:0] v;
    do_reset();
    wr(0, 0, 32'hA5A5_A5A5);
    n_checks++;
    if (out_strobe !== 4'b0001) begin
      n_fail++;
      $display("FAIL iso_strobe0: got %b want 0001", out_strobe);
    end
    wr(N_CH - 1, 0, 32'h5A5A_5A5A);
    n_checks++;
    if (out_strobe !== 4'b1000) begin
      n_fail++;
      $display("FAIL iso_strobe3: got %b want 1000", out_strobe);
    end
    wr(6, 0, 32'hFFFF_FFFF);
    n_checks++;
    if (out_strobe !== 4'b0000) begin
      n_fail++;
      $display("FAIL iso_unused_strobe: got %b want 0000", out_strobe);
    end
    n_checks++;
    if (out_port !== {32'h5A5A_5A5A, RESET_VAL, RESET_VAL, 32'hA5A5_A5A5}) begin
      n_fail++;
      $display("FAIL iso_out: got %h want %h", out_port,
               {32'h5A5A_5A5A, RESET_VAL, RESET_VAL, 32'hA5A5_A5A5});
    end
    for (int r = 0; r < 4; r++) begin
      rd(N_CH + 1, r, v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL iso_unused_read r%0d: got %h want 0", r, v);
      end
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] v;
    wr(N_CH, 1, 32'h1);
    in_port[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if (irq !== (t == 3)) begin
        n_fail++;
        $display("FAIL edge_irq_latency posedge %0d: got %b want %b", t, irq, (t == 3));
      end
    end
    wr(N_CH, 2, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_irq_clear: got %b want 0", irq);
    end
    in_port[1] = 1'b1;
    tick();
    in_port[1] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL masked_irq t%0d: got %b want 0", t, irq);
      end
    end
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL masked_edge: got %h want 00000002", v);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    wr(N_CH, 2, 32'h2);
    in_port[0] = 1'b0;
    tick();
    tick();
    tick();
    in_port[0] = 1'b1;
    tick();
    tick();
    tick();
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_pre: got %h irq %b want 00000001 irq 1", v, irq);
    end
    in_port[0] = 1'b0;
    tick();
    in_port[0] = 1'b1;
    tick();
    tick();
    // This write's clock edge is also the one that captures the second rise.
    wr(N_CH, 2, 32'h1);
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_set_wins: got %h irq %b want 00000001 irq 1", v, irq);
    end
    wr(N_CH, 2, 32'h1);
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_after: got %h irq %b want 0 irq 0", v, irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    in_port[0] = 1'b0;
    tick();
    tick();
    in_port[0] = 1'b1;
    tick();
    tick();
    tick();
    wr(2, 0, 32'h1357_9BDF);
    n_checks++;
    if (out_strobe !== 4'b0100 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got strobe %b irq %b want 0100 irq 1", out_strobe, irq);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_strobe !== 4'b0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_strobe_irq: got %b/%b want 0000/0", out_strobe, irq);
    end
    n_checks++;
    if (out_port !== {N_CH{RESET_VAL}}) begin
      n_fail++;
      $display("FAIL async_out: got %h want %h", out_port, {N_CH{RESET_VAL}});
    end
    rd(N_CH, 2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL async_edge: got %h want 0", v);
    end
    in_port = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0]      m_data [N_CH];
    logic [DATA_W-1:0]      hist [3];
    logic [DATA_W-1:0]      m_mask;
    logic [DATA_W-1:0]      m_edge;
    logic [DATA_W-1:0]      set_v;
    logic [DATA_W-1:0]      clr_v;
    logic [DATA_W-1:0]      exp_rd;
    logic [DATA_W-1:0]      dw;
    logic [N_CH*DATA_W-1:0] exp_out;
    logic [N_CH-1:0]        exp_strobe;
    logic                   we;
    int                     b;
    int                     r;
    do_reset();
    for (int c = 0; c < N_CH; c++) m_data[c] = RESET_VAL;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_mask = '0;
    m_edge = '0;
    for (int i = 0; i < 400; i++) begin
      b          = $urandom_range(0, 7);
      r          = $urandom_range(0, 3);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 1));
      writedata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      address    = adr(b, r);
      in_port    = in_port ^ (DATA_W'($urandom) & DATA_W'($urandom) & DATA_W'($urandom));
      dw         = DATA_W'(writedata);
      we         = chipselect && !write_n;

      // Synchronised input seen by software is the value sampled two posedges back.
      if (b < N_CH) exp_rd = m_data[b];
      else if (b == N_CH && r == 0) exp_rd = hist[1];
      else if (b == N_CH && r == 1) exp_rd = m_mask;
      else if (b == N_CH && r == 2) exp_rd = m_edge;
      else exp_rd = '0;
      #1;
      n_checks++;
      if (readdata !== 32'(exp_rd)) begin
        n_fail++;
        $display("FAIL rand_read cycle %0d b%0d r%0d: got %h want %h", i, b, r, readdata, exp_rd);
      end

      tick();
      set_v      = hist[1] & ~hist[2];
      clr_v      = (we && b == N_CH && r == 2) ? dw : '0;
      m_edge     = (m_edge & ~clr_v) | set_v;
      exp_strobe = '0;
      if (we && b < N_CH) begin
        exp_strobe[b] = 1'b1;
        case (r)
          0:       m_data[b] = dw;
          1:       m_data[b] = m_data[b] | dw;
          2:       m_data[b] = m_data[b] & ~dw;
          default: m_data[b] = m_data[b] ^ dw;
        endcase
      end else if (we && b == N_CH && r == 1) begin
        m_mask = dw;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = in_port;
      for (int c = 0; c < N_CH; c++) exp_out[c*DATA_W +: DATA_W] = m_data[c];

      n_checks++;
      if (out_port !== exp_out) begin
        n_fail++;
        $display("FAIL rand_out cycle %0d: got %h want %h", i, out_port, exp_out);
      end
      n_checks++;
      if (out_strobe !== exp_strobe) begin
        n_fail++;
        $display("FAIL rand_strobe cycle %0d: got %b want %b", i, out_strobe, exp_strobe);
      end
      n_checks++;
      if (irq !== (|(m_edge & m_mask))) begin
        n_fail++;
        $display("FAIL rand_irq cycle %0d: got %b want %b", i, irq, |(m_edge & m_mask));
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    in_port    = '0;
    test_reset();
    test_atomic();
    test_isolation();
    test_edge_irq();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_multi.md
# soc_system_pio_multi

Parametrised Avalon-MM parallel I/O peripheral on the HPS lightweight bridge, successor to the single 32-bit output PIO. Provides N_CH independent output registers of DATA_W bits. Each output register has atomic set, clear and toggle aliases and a one-cycle update strobe. One input bank adds a two-flop synchroniser, rising-edge capture and a maskable level interrupt.

## Interface

**Parameters**

- DATA_W, 32: bit width of each output channel and of the input bank; range 1..32.
- N_CH, 4: number of output channels; range 1..15.
- RESET_VAL, 0: reset value of every output register, DATA_W bits.
- CH_W, derived: clog2(N_CH+1); not user-set.

**Ports** (the bus is an Avalon-MM slave with zero read wait states)

- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  CH_W+2  word address; address[CH_W+1:2] is the bank, address[1:0] is the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above DATA_W are ignored.
- readdata  out  32  read data, combinational from address; bits above DATA_W read 0.
- out_port  out  N_CH*DATA_W  channel c occupies [c*DATA_W +: DATA_W].
- out_strobe  out  N_CH  one-cycle pulse per channel after any write to that channel.
- in_port  in  DATA_W  asynchronous inputs.
- irq  out  1  level interrupt, active high.

## Operation

- Write event: chipselect && !write_n, sampled on posedge clk.

**Output bank b < N_CH**

- Reg 0 DATA: read/write; write loads data[b] <= wd.
- Reg 1 SET: write gives data[b] <= data[b] | wd; reads return data[b].
- Reg 2 CLR: write gives data[b] <= data[b] & ~wd; reads return data[b].
- Reg 3 TGL: write gives data[b] <= data[b] ^ wd; reads return data[b].
- out_strobe[b] goes high for exactly the cycle after any write to bank b. This applies even if the value is unchanged, including a write of 0 to SET.

**Input bank b == N_CH**

- Reg 0 IN: read-only. Returns sync2 (see below); writes are ignored.
- Reg 1 MASK: read/write irq mask.
- Reg 2 EDGE: rising-edge capture. Reads return edge; writing 1 to a bit clears it (W1C).
- Reg 3: reads 0; writes are ignored.

**Synchroniser and edge capture**

- sync1 <= in_port; sync2 <= sync1; prev <= sync2.
- Per bit: edge[i] is set when sync2[i] && !prev[i].
- A set and a W1C clear in the same cycle: set wins, bit stays 1.

**Interrupt and unused banks**

- irq = |(edge & mask), driven from registers only, with no combinational path from in_port.
- Banks above N_CH read 0, ignore writes, and produce no strobe.

**Reset (asynchronous, while reset_n low)**

- data[*] = RESET_VAL.
- out_strobe = 0, mask = 0, edge = 0.
- sync1, sync2 and prev = 0; irq = 0.
- Reset asserted mid-pulse truncates the strobe immediately.

## Timing

- Write to out_port: out_port updates on the same posedge that samples the write and is visible the next cycle. out_strobe is high in that same cycle.
- Back-to-back writes to one bank: each write applies to the result of the previous one. out_strobe stays high continuously, one cycle per write.
- Read: readdata is valid in the same cycle as address. A read in the cycle of a write returns the pre-write value.
- in_port to edge bit: 3 posedges (sync1, sync2, capture). irq follows edge combinationally, with no extra cycle.
- Pulse width: any in_port pulse shorter than one clk period may be missed.
- After reset release: the first posedge uses prev = 0. An input already high at reset release therefore captures an edge 2 posedges after sync.

## Test plan

- Reset: hold reset_n low with in_port = all 1s -> out_port = RESET_VAL on every channel, out_strobe = 0, irq = 0, all readdata = 0 except DATA/SET/CLR/TGL, which return RESET_VAL.
- Atomic ops on ch1: write DATA 0x0000_00F0, SET 0x0F, CLR 0x30, TGL 0x101 -> values read back in order 0xF0, 0xFF, 0xCF, 0x1CE. out_strobe[1] high exactly 4 cycles; other strobes stay 0.
- Channel isolation: write DATA 0xA5A5A5A5 to ch0 and 0x5A5A5A5A to ch(N_CH-1) -> out_port slices match, middle channels keep RESET_VAL, bank N_CH+1 reads 0.
- Edge/irq: MASK = 0x1, then in_port[0] 0->1 -> irq rises on the 3rd posedge. Write EDGE 0x1 -> irq drops next cycle. Pulse in_port[1] with mask 0 -> EDGE reads 0x2 and irq stays 0.
- Simultaneous: W1C of edge bit 0 in the same cycle as a new rising capture on bit 0 -> EDGE still reads 0x1 and irq stays high.
- Async reset mid-operation: assert reset_n during an out_strobe pulse, between clock edges -> strobe, data, edge and irq clear immediately without waiting for clk.
